// File: rtl/fifo_sync_ext.sv
// Synchronous single-clock FIFO with first-word-fall-through or registered read output,
// threshold flags, overflow/underflow pulses and a post-reset busy window.
module fifo_sync_ext #(
    parameter int unsigned FIFO_DEPTH          = 16,
    parameter int unsigned DATA_WIDTH          = 32,
    parameter string       READ_MODE           = "fwft",
    parameter int unsigned ALMOST_FULL_THRESH  = FIFO_DEPTH - 2,
    parameter int unsigned ALMOST_EMPTY_THRESH = 2,
    parameter int unsigned RST_BUSY_CYCLES     = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    output logic                          rst_busy_o,
    input  logic                          wr_en_i,
    input  logic [DATA_WIDTH-1:0]         din_i,
    input  logic                          rd_en_i,
    output logic [DATA_WIDTH-1:0]         dout_o,
    output logic                          valid_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic                          almost_full_o,
    output logic                          almost_empty_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic                          overflow_o,
    output logic                          underflow_o
);

    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CW   = AW + 1;
    localparam int unsigned BW   = 4;
    localparam bit          FWFT = (READ_MODE == "fwft");

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  afull_q, afull_d;
    logic                  aempty_q, aempty_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  valid_q, valid_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  busy_q, busy_d;
    logic [BW-1:0]         busy_cnt_q, busy_cnt_d;
    logic                  wr_acc_c;
    logic                  rd_acc_c;

    // Acceptance looks only at registered flags, so a same-cycle read never frees room for a write.
    always_comb begin
        wr_acc_c   = wr_en_i && !full_q && !busy_q;
        rd_acc_c   = rd_en_i && !empty_q && !busy_q;

        wr_ptr_d   = wr_ptr_q + AW'(wr_acc_c);
        rd_ptr_d   = rd_ptr_q + AW'(rd_acc_c);
        count_d    = count_q + CW'(wr_acc_c) - CW'(rd_acc_c);
        full_d     = (count_d == CW'(FIFO_DEPTH));
        empty_d    = (count_d == '0);
        afull_d    = (count_d >= CW'(ALMOST_FULL_THRESH));
        aempty_d   = (count_d <= CW'(ALMOST_EMPTY_THRESH));
        ovf_d      = wr_en_i && full_q && !busy_q;
        unf_d      = rd_en_i && empty_q && !busy_q;

        busy_d     = busy_q;
        busy_cnt_d = busy_cnt_q;
        if (busy_q) begin
            if (busy_cnt_q == '0) begin
                busy_d = 1'b0;
            end else begin
                busy_cnt_d = busy_cnt_q - BW'(1);
            end
        end

        dout_d  = dout_q;
        valid_d = 1'b0;
        if (FWFT) begin
            // Head word after the edge; bypass din when the write lands on the new head slot.
            valid_d = !empty_d;
            if (!empty_d) begin
                dout_d = (wr_acc_c && (wr_ptr_q == rd_ptr_d)) ? din_i : mem[rd_ptr_d];
            end
        end else begin
            valid_d = rd_acc_c;
            if (rd_acc_c) begin
                dout_d = mem[rd_ptr_q];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_acc_c && !rst_i) begin
            mem[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            afull_q    <= 1'b0;
            aempty_q   <= 1'b1;
            dout_q     <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            busy_q     <= 1'b1;
            busy_cnt_q <= BW'(RST_BUSY_CYCLES);
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            afull_q    <= afull_d;
            aempty_q   <= aempty_d;
            dout_q     <= dout_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign rst_busy_o     = busy_q;
    assign dout_o         = dout_q;
    assign valid_o        = valid_q;
    assign full_o         = full_q;
    assign empty_o        = empty_q;
    assign almost_full_o  = afull_q;
    assign almost_empty_o = aempty_q;
    assign count_o        = count_q;
    assign overflow_o     = ovf_q;
    assign underflow_o    = unf_q;

endmodule

// File: tb/tb_fifo_sync_ext.sv
// Directed bench for fifo_sync_ext: one fwft instance and one std instance on a shared clock and reset.
module tb_fifo_sync_ext;

    logic        clk;
    logic        rst;

    logic        wr_f, rd_f;
    logic [31:0] din_f;
    logic        busy_f, valid_f, full_f, empty_f, af_f, ae_f, ovf_f, unf_f;
    logic [31:0] dout_f;
    logic [4:0]  count_f;

    logic        wr_s, rd_s;
    logic [31:0] din_s;
    logic        busy_s, valid_s, full_s, empty_s, af_s, ae_s, ovf_s, unf_s;
    logic [31:0] dout_s;
    logic [4:0]  count_s;

    int checks;
    int errors;

    fifo_sync_ext u_fwft (
        .clk_i(clk), .rst_i(rst), .rst_busy_o(busy_f),
        .wr_en_i(wr_f), .din_i(din_f), .rd_en_i(rd_f),
        .dout_o(dout_f), .valid_o(valid_f),
        .full_o(full_f), .empty_o(empty_f),
        .almost_full_o(af_f), .almost_empty_o(ae_f),
        .count_o(count_f), .overflow_o(ovf_f), .underflow_o(unf_f)
    );

    fifo_sync_ext #(.READ_MODE("std")) u_std (
        .clk_i(clk), .rst_i(rst), .rst_busy_o(busy_s),
        .wr_en_i(wr_s), .din_i(din_s), .rd_en_i(rd_s),
        .dout_o(dout_s), .valid_o(valid_s),
        .full_o(full_s), .empty_o(empty_s),
        .almost_full_o(af_s), .almost_empty_o(ae_s),
        .count_o(count_s), .overflow_o(ovf_s), .underflow_o(unf_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt_m;
        int nwr;
        int nrd;
        logic [31:0] exp_w;
        logic rd_acc;
        logic wr_acc;

        checks = 0;
        errors = 0;
        rst = 1'b1;
        wr_f = 1'b0; rd_f = 1'b0; din_f = '0;
        wr_s = 1'b0; rd_s = 1'b0; din_s = '0;

        repeat (3) tick();
        chk("rst_busy",   32'(busy_f),  32'd1);
        chk("rst_empty",  32'(empty_f), 32'd1);
        chk("rst_aempty", 32'(ae_f),    32'd1);
        chk("rst_count",  32'(count_f), 32'd0);
        chk("rst_full",   32'(full_f),  32'd0);
        chk("rst_afull",  32'(af_f),    32'd0);
        chk("rst_valid",  32'(valid_f), 32'd0);
        chk("rst_ovf",    32'(ovf_f),   32'd0);
        chk("rst_unf",    32'(unf_f),   32'd0);
        chk("rst_dout",   dout_f,       32'd0);
        chk("rst_dout_s", dout_s,       32'd0);
        chk("rst_valid_s", 32'(valid_s), 32'd0);

        // Busy window: high after release edges 1..4, low after edge 5.
        rst = 1'b0;
        tick();
        chk("busy_e1", 32'(busy_f), 32'd1);
        wr_f = 1'b1; rd_f = 1'b1; din_f = 32'hDEAD_0000;
        tick();
        wr_f = 1'b0; rd_f = 1'b0;
        chk("busy_e2", 32'(busy_f), 32'd1);
        chk("busy_wr_count", 32'(count_f), 32'd0);
        chk("busy_wr_ovf", 32'(ovf_f), 32'd0);
        chk("busy_rd_unf", 32'(unf_f), 32'd0);
        tick();
        chk("busy_e3", 32'(busy_f), 32'd1);
        tick();
        chk("busy_e4", 32'(busy_f), 32'd1);
        tick();
        chk("busy_e5", 32'(busy_f), 32'd0);
        chk("busy_e5_std", 32'(busy_s), 32'd0);
        chk("post_busy_empty", 32'(empty_f), 32'd1);

        // Single word fall-through.
        wr_f = 1'b1; din_f = 32'hA5A5_0001;
        tick();
        wr_f = 1'b0;
        chk("fwft1_empty", 32'(empty_f), 32'd0);
        chk("fwft1_valid", 32'(valid_f), 32'd1);
        chk("fwft1_dout",  dout_f,       32'hA5A5_0001);
        chk("fwft1_count", 32'(count_f), 32'd1);
        rd_f = 1'b1;
        tick();
        rd_f = 1'b0;
        chk("fwft1_rd_empty", 32'(empty_f), 32'd1);
        chk("fwft1_rd_count", 32'(count_f), 32'd0);
        chk("fwft1_rd_valid", 32'(valid_f), 32'd0);

        // Fill to full with flag thresholds.
        for (int i = 0; i < 16; i++) begin
            wr_f = 1'b1; din_f = 32'(i);
            tick();
            chk("fill_count", 32'(count_f), 32'(i + 1));
            chk("fill_afull", 32'(af_f),    32'((i + 1) >= 14));
            chk("fill_aempty", 32'(ae_f),   32'((i + 1) <= 2));
            chk("fill_full",  32'(full_f),  32'((i + 1) == 16));
        end
        wr_f = 1'b1; din_f = 32'h0000_0099;
        tick();
        wr_f = 1'b0;
        chk("ovf_pulse", 32'(ovf_f),   32'd1);
        chk("ovf_count", 32'(count_f), 32'd16);
        tick();
        chk("ovf_clear", 32'(ovf_f),   32'd0);
        chk("full_head", dout_f,       32'd0);

        // Full with simultaneous read and write: only the read is accepted.
        wr_f = 1'b1; rd_f = 1'b1; din_f = 32'h0000_0077;
        tick();
        wr_f = 1'b0; rd_f = 1'b0;
        chk("fullrw_count", 32'(count_f), 32'd15);
        chk("fullrw_ovf",   32'(ovf_f),   32'd1);
        chk("fullrw_full",  32'(full_f),  32'd0);

        for (int i = 1; i < 16; i++) begin
            chk("drain_dout",  dout_f,       32'(i));
            chk("drain_valid", 32'(valid_f), 32'd1);
            rd_f = 1'b1;
            tick();
        end
        rd_f = 1'b0;
        chk("drain_empty", 32'(empty_f), 32'd1);
        chk("drain_count", 32'(count_f), 32'd0);

        // Empty with simultaneous read and write: only the write is accepted.
        wr_f = 1'b1; rd_f = 1'b1; din_f = 32'h0000_BEEF;
        tick();
        wr_f = 1'b0; rd_f = 1'b0;
        chk("emptyrw_unf",   32'(unf_f),   32'd1);
        chk("emptyrw_count", 32'(count_f), 32'd1);
        chk("emptyrw_dout",  dout_f,       32'h0000_BEEF);
        tick();
        chk("emptyrw_unf_clear", 32'(unf_f), 32'd0);

        // Registered-read mode: 3 preloaded words, then 20 writes alongside continuous reads.
        for (int i = 0; i < 3; i++) begin
            wr_s = 1'b1; din_s = 32'(100 + i);
            tick();
            chk("std_pre_valid", 32'(valid_s), 32'd0);
        end
        wr_s = 1'b0;
        chk("std_pre_count", 32'(count_s), 32'd3);
        cnt_m = 3;
        nwr = 0;
        nrd = 0;
        for (int c = 0; c < 24; c++) begin
            wr_s = (nwr < 20);
            din_s = 32'(200 + nwr);
            rd_s = (cnt_m > 0);
            rd_acc = rd_s && (cnt_m > 0);
            wr_acc = wr_s && (cnt_m < 16);
            tick();
            chk("std_valid", 32'(valid_s), 32'(rd_acc));
            if (rd_acc) begin
                exp_w = (nrd < 3) ? 32'(100 + nrd) : 32'(200 + nrd - 3);
                chk("std_dout", dout_s, exp_w);
                nrd++;
            end
            if (wr_acc) nwr++;
            cnt_m = cnt_m + int'(wr_acc) - int'(rd_acc);
        end
        wr_s = 1'b0; rd_s = 1'b0;
        chk("std_reads", 32'(nrd), 32'd23);
        chk("std_end_count", 32'(count_s), 32'd0);
        tick();
        chk("std_hold_valid", 32'(valid_s), 32'd0);
        chk("std_hold_dout", dout_s, 32'd219);

        // Mid-operation reset with pending requests discards contents quietly.
        chk("midrst_pre_count", 32'(count_f), 32'd1);
        wr_f = 1'b1; din_f = 32'h0000_1234;
        tick();
        wr_f = 1'b1; rd_f = 1'b1; rst = 1'b1;
        tick();
        wr_f = 1'b0; rd_f = 1'b0;
        chk("midrst_count", 32'(count_f), 32'd0);
        chk("midrst_empty", 32'(empty_f), 32'd1);
        chk("midrst_ovf",   32'(ovf_f),   32'd0);
        chk("midrst_unf",   32'(unf_f),   32'd0);
        chk("midrst_busy",  32'(busy_f),  32'd1);
        chk("midrst_valid", 32'(valid_f), 32'd0);
        rst = 1'b0;
        repeat (5) tick();
        chk("midrst_release", 32'(busy_f), 32'd0);
        chk("midrst_still_empty", 32'(empty_f), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
